// File: rtl/display_v2.sv
// Avalon-ST word FIFO feeding a board display: words are popped on a periodic
// tick (or a manual key press) and shown on eight 7-segment digits plus LEDs.
module display_v2 #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic              clk_hifreq,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    input  logic [17:0]       switches,
    input  logic [3:0]        buttons,
    output logic [7:0]        leds_green,
    output logic [17:0]       leds_red,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5,
    output logic [6:0]        hex6,
    output logic [6:0]        hex7
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TICK_DIV);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head_reg;
    logic [PW-1:0]     tail_reg;
    logic [CW-1:0]     count_reg;
    logic [TW-1:0]     tick_cnt_reg;
    logic [2:0]        sync1_reg;
    logic [2:0]        sync2_reg;
    logic [2:0]        sync_prev_reg;
    logic              underflow_reg;
    logic [DATA_W-1:0] disp_word_reg;

    logic [2:0]  press;
    logic        tick;
    logic        flush_pulse;
    logic        push;
    logic        pop_req;
    logic        pop;
    logic        uf_set;
    logic [31:0] word32;
    logic        unused_inputs;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Keys are active-low: a press is the synchronised level going 1 -> 0.
    assign press       = sync_prev_reg & ~sync2_reg;
    assign flush_pulse = press[2];
    assign tick        = (tick_cnt_reg == TW'(TICK_DIV - 1));
    assign ready       = (count_reg < CW'(DEPTH)) && !flush_pulse && !rst;
    assign push        = valid && ready;
    assign pop_req     = (switches[17] ? press[0] : tick) && !switches[16] && !flush_pulse;
    assign pop         = pop_req && (count_reg != '0);
    assign uf_set      = pop_req && (count_reg == '0);
    assign word32      = 32'(disp_word_reg);

    assign unused_inputs = ^{switches[14:0], buttons[3]};

    always_ff @(posedge clk_hifreq) begin
        if (push) begin
            mem[tail_reg] <= data_in;
        end
    end

    always_ff @(posedge clk_hifreq or posedge rst) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            tick_cnt_reg  <= '0;
            sync1_reg     <= '0;
            sync2_reg     <= '0;
            sync_prev_reg <= '0;
            underflow_reg <= 1'b0;
            disp_word_reg <= '0;
            leds_green    <= '0;
            leds_red      <= '0;
        end else begin
            tick_cnt_reg  <= tick ? '0 : tick_cnt_reg + 1'b1;
            sync1_reg     <= buttons[2:0];
            sync2_reg     <= sync1_reg;
            sync_prev_reg <= sync2_reg;

            if (flush_pulse) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) begin
                    tail_reg <= tail_reg + 1'b1;
                end
                if (pop) begin
                    head_reg      <= head_reg + 1'b1;
                    disp_word_reg <= mem[head_reg];
                end
                if (push && !pop) begin
                    count_reg <= count_reg + 1'b1;
                end else if (pop && !push) begin
                    count_reg <= count_reg - 1'b1;
                end
            end

            // A simultaneous underflow and clear request leaves the flag set.
            if (uf_set) begin
                underflow_reg <= 1'b1;
            end else if (press[1]) begin
                underflow_reg <= 1'b0;
            end

            leds_green <= {{(8 - CW){1'b0}}, count_reg};
            leds_red   <= {(count_reg == CW'(DEPTH)), underflow_reg, disp_word_reg[15:0]};
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_hex
        logic [6:0] seg_reg;
        always_ff @(posedge clk_hifreq or posedge rst) begin
            if (rst) begin
                seg_reg <= 7'h40;
            end else begin
                seg_reg <= switches[15] ? 7'h7F : seg7(word32[4*gi +: 4]);
            end
        end
    end

    assign hex0 = g_hex[0].seg_reg;
    assign hex1 = g_hex[1].seg_reg;
    assign hex2 = g_hex[2].seg_reg;
    assign hex3 = g_hex[3].seg_reg;
    assign hex4 = g_hex[4].seg_reg;
    assign hex5 = g_hex[5].seg_reg;
    assign hex6 = g_hex[6].seg_reg;
    assign hex7 = g_hex[7].seg_reg;
endmodule

// File: tb/tb_display_v2.sv
// Bench for display_v2: directed scenarios followed by random traffic, every
// cycle compared against a queue-based model of the display behaviour.
module tb_display_v2;
    localparam int DW = 32;
    localparam int DP = 4;
    localparam int TD = 4;

    logic          clk_hifreq = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic [17:0]   switches = '0;
    logic [3:0]    buttons = 4'hF;
    logic [7:0]    leds_green;
    logic [17:0]   leds_red;
    logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [6:0]    hexs [8];

    display_v2 #(.DATA_W(DW), .DEPTH(DP), .TICK_DIV(TD)) dut (
        .clk_hifreq(clk_hifreq), .rst(rst), .data_in(data_in), .valid(valid),
        .ready(ready), .switches(switches), .buttons(buttons),
        .leds_green(leds_green), .leds_red(leds_red),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
    );

    assign hexs[0] = hex0;
    assign hexs[1] = hex1;
    assign hexs[2] = hex2;
    assign hexs[3] = hex3;
    assign hexs[4] = hex4;
    assign hexs[5] = hex5;
    assign hexs[6] = hex6;
    assign hexs[7] = hex7;

    always #5 clk_hifreq = ~clk_hifreq;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of words, the shown word, the sticky flag and
    // the per-edge history of raw key levels.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_disp;
    bit            m_uf;
    int            m_n;
    logic [2:0]    b_d1, b_d2, b_d3;
    logic [7:0]    e_green;
    logic [17:0]   e_red;
    logic [6:0]    e_hex [8];
    logic [6:0]    seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] seg_of(input logic [31:0] w, input int i);
        logic [3:0] nib;
        nib = 4'(w >> (4 * i));
        return seg_tab[nib];
    endfunction

    task automatic model_reset;
        q.delete();
        m_disp = '0;
        m_uf = 0;
        m_n = 0;
        b_d1 = '0;
        b_d2 = '0;
        b_d3 = '0;
        e_green = '0;
        e_red = '0;
        for (int i = 0; i < 8; i++) e_hex[i] = 7'h40;
    endtask

    task automatic model_edge;
        logic [2:0] pr;
        bit tk, fl, ps, preq;
        int sz;
        m_n++;
        tk = (m_n % TD == 0);
        pr = b_d3 & ~b_d2;
        sz = q.size();
        e_green = 8'(sz);
        e_red = {(sz == DP), m_uf, m_disp[15:0]};
        for (int i = 0; i < 8; i++) e_hex[i] = switches[15] ? 7'h7F : seg_of(32'(m_disp), i);
        fl = pr[2];
        ps = valid && (sz < DP) && !fl;
        preq = (switches[17] ? pr[0] : tk) && !switches[16] && !fl;
        if (fl) q.delete();
        else if (preq && sz > 0) m_disp = q.pop_front();
        if (preq && sz == 0) m_uf = 1;
        else if (pr[1]) m_uf = 0;
        if (ps) q.push_back(data_in);
        b_d3 = b_d2;
        b_d2 = b_d1;
        b_d1 = buttons[2:0];
    endtask

    always @(posedge clk_hifreq or posedge rst) begin
        if (rst) model_reset();
        else model_edge();
    end

    task automatic compare_outputs;
        logic [2:0] pend;
        pend = b_d3 & ~b_d2;
        check("ready", ready, (!rst && q.size() < DP && !pend[2]));
        check("leds_green", leds_green, e_green);
        check("leds_red", leds_red, e_red);
        for (int i = 0; i < 8; i++) check($sformatf("hex%0d", i), hexs[i], e_hex[i]);
    endtask

    task automatic step;
        @(negedge clk_hifreq);
        compare_outputs();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        valid = 1'b1;
        data_in = w;
        #1 check("push_ready", ready, 1);
        step();
        valid = 1'b0;
    endtask

    task automatic wait_disp(input logic [15:0] w, input string tag);
        for (int i = 0; i < 20; i++) begin
            step();
            if (leds_red[15:0] == w) break;
        end
        check(tag, leds_red[15:0], w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit took;
        repeat (3) step();
        rst = 1'b0;

        // Two back-to-back words shown one per tick
        valid = 1'b1;
        data_in = 32'h0000_1234;
        #1 check("b2b_ready0", ready, 1);
        step();
        data_in = 32'h0000_ABCD;
        #1 check("b2b_ready1", ready, 1);
        step();
        valid = 1'b0;
        wait_disp(16'h1234, "disp_1234");
        check("hex_1234", {hex3, hex2, hex1, hex0}, {7'h79, 7'h24, 7'h30, 7'h19});
        wait_disp(16'hABCD, "disp_abcd");
        check("hex_abcd", {hex3, hex2, hex1, hex0}, {7'h08, 7'h03, 7'h46, 7'h21});

        // Underflow on empty tick, then cleared by key 1
        repeat (6) step();
        check("uf_set", leds_red[16], 1);
        check("uf_disp_held", leds_red[15:0], 16'hABCD);
        switches[17] = 1'b1;
        buttons[1] = 1'b0;
        repeat (4) step();
        check("uf_clear", leds_red[16], 0);
        buttons[1] = 1'b1;

        // Fill to full with pops frozen; fifth word waits for space
        switches[17] = 1'b0;
        switches[16] = 1'b1;
        for (int i = 0; i < 4; i++) push_word($urandom);
        valid = 1'b1;
        data_in = 32'h5555_0005;
        repeat (3) step();
        check("full_ready", ready, 0);
        check("full_led", leds_red[17], 1);
        check("full_green", leds_green, 4);
        switches[16] = 1'b0;
        took = 0;
        for (int i = 0; i < 12 && !took; i++) begin
            step();
            if (ready) took = 1;
        end
        check("fifth_accepted", took, 1);
        step();
        valid = 1'b0;

        // Manual mode: no pop on ticks, one pop per held press
        repeat (30) step();
        switches[17] = 1'b1;
        push_word(32'h0000_1111);
        push_word(32'h0000_2222);
        repeat (12) step();
        check("manual_hold", leds_green, 2);
        buttons[0] = 1'b0;
        repeat (6) step();
        buttons[0] = 1'b1;
        repeat (3) step();
        check("manual_one_pop", leds_green, 1);
        check("manual_disp", leds_red[15:0], 16'h1111);

        // Flush with count=3 while the source offers a word
        push_word(32'h0000_3333);
        push_word(32'h0000_4444);
        buttons[2] = 1'b0;
        step();
        step();
        valid = 1'b1;
        data_in = 32'h0000_9999;
        #1 check("flush_ready", ready, 0);
        step();
        valid = 1'b0;
        buttons[2] = 1'b1;
        step();
        check("flush_green", leds_green, 0);
        check("flush_disp", leds_red[15:0], 16'h1111);

        // Asynchronous reset between edges with two words queued
        push_word(32'h0000_5555);
        push_word(32'h0000_6666);
        #2 rst = 1'b1;
        #1 compare_outputs();
        check("rst_green", leds_green, 0);
        check("rst_red", leds_red, 0);
        check("rst_hex0", hex0, 7'h40);
        check("rst_ready", ready, 0);
        step();
        step();
        #2 rst = 1'b0;
        #1 check("post_rst_ready", ready, 1);
        switches = '0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            valid = 1'($urandom_range(0, 1));
            data_in = $urandom;
            if ($urandom_range(0, 40) == 0) switches = 18'($urandom);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 15) == 0) buttons[b] = ~buttons[b];
            end
            if ($urandom_range(0, 500) == 0) begin
                #2 rst = 1'b1;
                #1 compare_outputs();
                step();
                #2 rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/display_v2.md
DISPLAY_V2 -- requirements
Module: display_v2

Interface
REQ-001 Parameter DATA_W, default 32: Avalon-ST data width; legal range 16..32.
REQ-002 Parameter DEPTH, default 8: FIFO depth in words; power of two, 2..64.
REQ-003 Parameter TICK_DIV, default 50_000_000: clk_hifreq cycles per display tick; at least 2.
REQ-004 Port clk_hifreq  in  1: single clock for all logic; rising edge.
REQ-005 Port rst  in  1: reset, asynchronous and active-high.
REQ-006 Port data_in  in  DATA_W: Avalon-ST data.
REQ-007 Port valid  in  1: Avalon-ST valid.
REQ-008 Port ready  out  1: Avalon-ST ready.
REQ-009 Port switches  in  18: [17] manual mode, [16] freeze, [15] hex blank; remaining bits unused.
REQ-010 Port buttons  in  4: active-low keys; [0] step, [1] clear underflow flag, [2] flush; [3] unused.
REQ-011 Port leds_green  out  8: FIFO fill count.
REQ-012 Port leds_red  out  18: [15:0] displayed word low half, [16] sticky underflow, [17] FIFO full.
REQ-013 Ports hex0..hex7  out  7 each: active-low segments {g,f,e,d,c,b,a}; hexN shows nibble N.

Function
REQ-014 Transfer occurs on a clk_hifreq edge where valid and ready are both 1; the word is written at the FIFO tail.
REQ-015 ready is combinational: 1 when count < DEPTH, flush_pulse is 0 and rst is 0; otherwise 0.
REQ-016 count is clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH; with push and pop in the same cycle, count is unchanged.
REQ-017 Tick counter runs 0..TICK_DIV-1 and wraps; tick is a 1-cycle pulse in the cycle where the counter equals TICK_DIV-1.
REQ-018 Each of buttons[2:0] passes through a 2-flop synchroniser; a press is a 1-cycle pulse on the synchronised falling edge.
REQ-019 Pop request: tick when switches[17]=0; buttons[0] press when switches[17]=1; suppressed while switches[16]=1.
REQ-020 Pop occurs when a pop request is present and count > 0; disp_word takes the FIFO head at that edge; outputs reflect it one cycle later.
REQ-021 A pop request with count=0 sets the sticky underflow flag; disp_word is held.
REQ-022 A buttons[1] press clears underflow; if a set and a clear occur in the same cycle, set wins.
REQ-023 flush_pulse (buttons[2] press) sets count and both pointers to 0; it overrides push and pop in the same cycle; disp_word is held.
REQ-024 hexN = 7-segment code of nibble N of disp_word, zero-extended to 32 bits; codes are 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-025 When switches[15]=1, all hex outputs are 7'h7F; switches[15] does not affect LEDs or the FIFO.
REQ-026 leds_green = count, saturated at 255.
REQ-027 leds_red[17] = (count == DEPTH).
REQ-028 All outputs except ready are registered.

Reset
REQ-029 While rst=1: count, pointers, tick counter, synchronisers, underflow and disp_word are 0; ready=0; leds_green=0; leds_red=0; all hex=7'h40.
REQ-030 rst asserted mid-operation discards FIFO contents and any pending pop immediately; the first tick after release occurs TICK_DIV cycles later.
REQ-031 FIFO storage array needs no reset; it is unreadable until written.

Verification
REQ-032 TICK_DIV=4, DEPTH=4; push 0x0000_1234, 0x0000_ABCD back-to-back -> ready stays 1; hex3..0 show 1,2,3,4 after the first tick, then A,b,C,d after the next tick; leds_green goes 2,1,0.
REQ-033 Push 5 words with DEPTH=4 and no pops -> ready=0 after 4 transfers; leds_red[17]=1; leds_green=4; the 5th word is held by the source until a pop, then accepted.
REQ-034 FIFO empty, tick occurs -> leds_red[16]=1 and disp_word unchanged; buttons[1] press -> leds_red[16]=0 within 4 cycles.
REQ-035 switches[17]=1, 2 words queued, no button activity across 3 ticks -> no pop; one buttons[0] press -> exactly one pop; a glitch-free held press yields a single pop.
REQ-036 Count=3; flush press coincides with valid=1 -> word not accepted (ready=0 that cycle); count=0 the next cycle; display unchanged.
REQ-037 rst pulsed asynchronously between clock edges with count=2 -> all outputs take their reset values immediately; ready=1 on the first edge after release.
